seq_detect_param: RTL and testbench
===================================

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 The block SHALL have parameter SYM_W, default 2, giving the width of one input symbol.
REQ-002 The block SHALL have parameter SEQ_LEN, default 4, giving the pattern length in symbols (legal range 2..16).
REQ-003 The block SHALL have parameter CNT_W, default 8, giving the width of the match counter.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 res  input  1  reset; synchronous and active-low.
REQ-006 sym_in  input  SYM_W  symbol, sampled only when sym_vld=1.
REQ-007 sym_vld  input  1  qualifies sym_in for the current cycle.
REQ-008 pat_in  input  SEQ_LEN*SYM_W  pattern; symbol 0 (first expected) sits in the LSBs.
REQ-009 load  input  1  one-cycle strobe that latches pat_in and arms the detector.
REQ-010 ovl  input  1  mode: 1 = overlapping matches allowed; 0 = non-overlapping.
REQ-011 cnt_clr  input  1  synchronous clear of match_cnt.
REQ-012 y  output  1  registered one-cycle match pulse.
REQ-013 match_cnt  output  CNT_W  saturating count of matches.
REQ-014 armed  output  1  high when the detector is in FILL or HUNT.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE (not armed), FILL (fewer than SEQ_LEN valid symbols held), and HUNT (history is full and each valid symbol is compared).
REQ-016 IDLE SHALL ignore sym_vld, and load SHALL move IDLE to FILL.
REQ-017 Each cycle with sym_vld=1 in FILL or HUNT SHALL shift sym_in into a SEQ_LEN-deep history and increment a fill counter; FILL SHALL move to HUNT when the fill counter reaches SEQ_LEN.
REQ-018 A match SHALL be the cycle in which the newest SEQ_LEN valid symbols, oldest first, equal pattern symbols 0..SEQ_LEN-1.
REQ-019 A match SHALL be detected on the cycle the completing symbol is sampled, so y=1 on the next cycle (latency 1) for exactly one cycle.
REQ-020 Cycles with sym_vld=0 SHALL neither shift the history nor break a partial sequence.
REQ-021 When ovl=1 and a match occurs, the FSM SHALL stay in HUNT with the history retained.
REQ-022 When ovl=0 and a match occurs, the history and fill counter SHALL clear and the FSM SHALL return to FILL.
REQ-023 ovl SHALL be sampled every cycle; changing it mid-stream SHALL affect only later matches.
REQ-024 load in FILL or HUNT SHALL relatch the pattern, clear the history and fill counter, enter FILL, and discard any sym_in in the same cycle (load wins).
REQ-025 Each match SHALL increment match_cnt, which saturates at 2^CNT_W-1 while y keeps pulsing.
REQ-026 If cnt_clr and a match coincide, match_cnt SHALL become 0 and y SHALL still pulse.
REQ-027 armed SHALL be a registered output: 0 in IDLE, 1 in FILL and HUNT.

Reset
REQ-028 When res=0 at a rising clk edge, the block SHALL set state=IDLE, y=0, match_cnt=0, armed=0, and clear the pattern register, history and fill counter.
REQ-029 res=0 SHALL override load, sym_vld and cnt_clr in the same cycle.
REQ-030 After reset the block SHALL require a load before detecting.

Structure
REQ-031 The FSM state encoding (IDLE, FILL, HUNT) SHALL live in a shared package seq_detect_pkg.
REQ-032 One sub-module, sym_hist_shreg (parametrised SYM_W x SEQ_LEN shift register with clear and enable), SHALL hold the history; comparison and FSM logic SHALL stay in the top.

Verification
REQ-033 Basic match: defaults, pat_in=8'h39, load, then stream 01,10,11,00 -> y=1 exactly one cycle after the 00 is sampled, and match_cnt=1.
REQ-034 Mode: pat_in=8'h55, six consecutive 01 symbols -> ovl=1 gives 3 y pulses and match_cnt=3; ovl=0 gives 1 pulse and match_cnt=1.
REQ-035 Gaps: pattern 8'h39 with sym_vld=0 for 3 cycles between each symbol -> exactly 1 pulse, 1 cycle after the last valid symbol.
REQ-036 Saturation/clear: CNT_W=2, 5 matches -> match_cnt=3; cnt_clr coincident with the 6th match -> match_cnt=0 and y=1.
REQ-037 Reset mid-stream: res=0 after 3 of 4 pattern symbols, then the 4th symbol -> y=0, armed=0, match_cnt=0; no match until load is reissued.
REQ-038 Load collision: load with sym_vld=1 after 3 matching symbols -> the symbol is discarded, armed=1, and a full 4-symbol sequence is needed for the next pulse.

Source files
------------

// File: rtl/seq_detect_pkg.sv
// -----------------------------------------------------------------------------
// seq_detect_pkg
// Shared definitions for the parametrised sequence detector.
//   state_t   : detector FSM encoding (IDLE, FILL, HUNT)
//   fill_w()  : width needed to count 0..seq_len valid symbols
// -----------------------------------------------------------------------------
package seq_detect_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,    // not armed, symbols ignored
        FILL = 2'd1,    // fewer than SEQ_LEN valid symbols held since arm/clear
        HUNT = 2'd2     // history full, every valid symbol is compared
    } state_t;

    function automatic int fill_w(input int seq_len);
        return $clog2(seq_len + 1);
    endfunction

endpackage

// File: rtl/sym_hist_shreg.sv
// -----------------------------------------------------------------------------
// sym_hist_shreg
// SEQ_LEN-deep shift register of SYM_W-bit symbols with clear and enable.
// Symbol 0 (oldest) sits in the LSBs; a shift drops the oldest symbol and
// places i_sym in the top slot.
//   clk          : clock
//   res          : synchronous active-low reset
//   i_clr        : clear all stages (wins over i_en)
//   i_en         : shift i_sym in
//   i_sym        : incoming symbol
//   o_hist_next  : history as it will be after this edge when not cleared
//                  (shifted view when i_en=1, current contents otherwise)
// -----------------------------------------------------------------------------
module sym_hist_shreg #(
    parameter int SYM_W   = 2,
    parameter int SEQ_LEN = 4
) (
    input  logic                     clk,
    input  logic                     res,
    input  logic                     i_clr,
    input  logic                     i_en,
    input  logic [SYM_W-1:0]         i_sym,
    output logic [SEQ_LEN*SYM_W-1:0] o_hist_next
);

    localparam int HIST_W = SEQ_LEN * SYM_W;

    logic [HIST_W-1:0] r_hist;
    logic [HIST_W-1:0] w_shift;

    // Each slot takes the next-newer slot; the newest slot takes i_sym.
    genvar gi;
    generate
        for (gi = 0; gi < SEQ_LEN; gi++) begin : g_stage
            if (gi == SEQ_LEN - 1) begin : g_top
                assign w_shift[gi*SYM_W +: SYM_W] = i_sym;
            end else begin : g_mid
                assign w_shift[gi*SYM_W +: SYM_W] = r_hist[(gi+1)*SYM_W +: SYM_W];
            end
        end
    endgenerate

    assign o_hist_next = i_en ? w_shift : r_hist;

    always_ff @(posedge clk) begin
        if (!res) begin
            r_hist <= '0;
        end else if (i_clr) begin
            r_hist <= '0;
        end else begin
            r_hist <= o_hist_next;
        end
    end

endmodule

// File: rtl/seq_detect_param.sv
// -----------------------------------------------------------------------------
// seq_detect_param
// Parametrised symbol-sequence detector with overlapping / non-overlapping
// mode, registered match pulse and saturating match counter.
//   clk        : clock, rising edge
//   res        : synchronous active-low reset
//   sym_in     : input symbol, qualified by sym_vld
//   sym_vld    : sym_in valid this cycle
//   pat_in     : pattern, symbol 0 (first expected) in the LSBs
//   load       : latch pat_in and (re)arm; wins over a same-cycle symbol
//   ovl        : 1 = overlapping matches, 0 = history restarts after a match
//   cnt_clr    : synchronous clear of match_cnt (wins over a same-cycle match)
//   y          : one-cycle match pulse, one cycle after the completing symbol
//   match_cnt  : saturating match count
//   armed      : detector is in FILL or HUNT
// -----------------------------------------------------------------------------
module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter int SYM_W   = 2,
    parameter int SEQ_LEN = 4,
    parameter int CNT_W   = 8
) (
    input  logic                     clk,
    input  logic                     res,
    input  logic [SYM_W-1:0]         sym_in,
    input  logic                     sym_vld,
    input  logic [SEQ_LEN*SYM_W-1:0] pat_in,
    input  logic                     load,
    input  logic                     ovl,
    input  logic                     cnt_clr,
    output logic                     y,
    output logic [CNT_W-1:0]         match_cnt,
    output logic                     armed
);

    localparam int PAT_W  = SEQ_LEN * SYM_W;
    localparam int FILL_W = fill_w(SEQ_LEN);

    state_t              r_state;
    state_t              w_state_next;
    logic [PAT_W-1:0]    r_pat;
    logic [FILL_W-1:0]   r_fill;
    logic [FILL_W-1:0]   w_fill_next;
    logic                r_y;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_armed;

    logic                w_hist_en;
    logic                w_hist_clr;
    logic                w_match;
    logic [PAT_W-1:0]    w_hist_next;

    // Shift enable depends only on inputs and state, never on the match
    // result, so the compare path through the history mux stays acyclic.
    assign w_hist_en = !load && (r_state != IDLE) && sym_vld;

    sym_hist_shreg #(
        .SYM_W   (SYM_W),
        .SEQ_LEN (SEQ_LEN)
    ) u_hist (
        .clk         (clk),
        .res         (res),
        .i_clr       (w_hist_clr),
        .i_en        (w_hist_en),
        .i_sym       (sym_in),
        .o_hist_next (w_hist_next)
    );

    always_comb begin
        w_state_next = r_state;
        w_fill_next  = r_fill;
        w_hist_clr   = 1'b0;
        w_match      = 1'b0;

        if (load) begin
            w_state_next = FILL;
            w_fill_next  = '0;
            w_hist_clr   = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_next = IDLE;
                end
                FILL, HUNT: begin
                    if (sym_vld) begin
                        // The window is complete either already (HUNT) or
                        // with this very symbol (last FILL slot).
                        if ((r_state == HUNT) || (r_fill == FILL_W'(SEQ_LEN - 1))) begin
                            w_match = (w_hist_next == r_pat);
                            if (w_match && !ovl) begin
                                w_state_next = FILL;
                                w_fill_next  = '0;
                                w_hist_clr   = 1'b1;
                            end else begin
                                w_state_next = HUNT;
                                w_fill_next  = FILL_W'(SEQ_LEN);
                            end
                        end else begin
                            w_fill_next = r_fill + 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!res) begin
            r_state <= IDLE;
            r_fill  <= '0;
            r_pat   <= '0;
            r_y     <= 1'b0;
            r_cnt   <= '0;
            r_armed <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_fill  <= w_fill_next;
            if (load) begin
                r_pat <= pat_in;
            end
            r_y     <= w_match;
            r_armed <= (w_state_next != IDLE);
            if (cnt_clr) begin
                r_cnt <= '0;
            end else if (w_match && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign y         = r_y;
    assign match_cnt = r_cnt;
    assign armed     = r_armed;

endmodule

// File: tb/tb_seq_detect_param.sv
module tb_seq_detect_param;

    localparam int SYM_W   = 2;
    localparam int SEQ_LEN = 4;

    logic       clk;
    logic       res;
    logic [1:0] sym_in;
    logic       sym_vld;
    logic [7:0] pat_in;
    logic       load;
    logic       ovl;
    logic       cnt_clr;

    logic       y_a, armed_a;
    logic [7:0] match_cnt_a;
    logic       y_b, armed_b;
    logic [1:0] match_cnt_b;

    // Default counter width
    seq_detect_param u_dut_a (
        .clk       (clk),
        .res       (res),
        .sym_in    (sym_in),
        .sym_vld   (sym_vld),
        .pat_in    (pat_in),
        .load      (load),
        .ovl       (ovl),
        .cnt_clr   (cnt_clr),
        .y         (y_a),
        .match_cnt (match_cnt_a),
        .armed     (armed_a)
    );

    // Narrow counter for saturation
    seq_detect_param #(.CNT_W(2)) u_dut_b (
        .clk       (clk),
        .res       (res),
        .sym_in    (sym_in),
        .sym_vld   (sym_vld),
        .pat_in    (pat_in),
        .load      (load),
        .ovl       (ovl),
        .cnt_clr   (cnt_clr),
        .y         (y_b),
        .match_cnt (match_cnt_b),
        .armed     (armed_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks  = 0;
    int n_errors  = 0;
    int cyc_no    = 0;
    int pulse_cnt = 0;
    logic cur_ovl = 1'b1;

    // Behavioural reference: a list of valid symbols seen since arm/clear.
    logic [1:0] mq[$];
    logic [7:0] m_pat;
    logic       m_armed;
    logic       m_y;
    int         m_cnt_a;
    int         m_cnt_b;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_no);
        end
    endtask

    task automatic model_step();
        logic hit;
        hit = 1'b0;
        if (!res) begin
            mq.delete();
            m_pat   = '0;
            m_armed = 1'b0;
            m_y     = 1'b0;
            m_cnt_a = 0;
            m_cnt_b = 0;
        end else begin
            if (load) begin
                m_pat   = pat_in;
                mq.delete();
                m_armed = 1'b1;
            end else if (m_armed && sym_vld) begin
                mq.push_back(sym_in);
                if (mq.size() > SEQ_LEN) void'(mq.pop_front());
                if (mq.size() == SEQ_LEN) begin
                    hit = 1'b1;
                    for (int k = 0; k < SEQ_LEN; k++)
                        if (mq[k] != m_pat[k*SYM_W +: SYM_W]) hit = 1'b0;
                end
                if (hit && !ovl) mq.delete();
            end
            m_y = hit;
            if (cnt_clr) begin
                m_cnt_a = 0;
                m_cnt_b = 0;
            end else if (hit) begin
                if (m_cnt_a < 255) m_cnt_a++;
                if (m_cnt_b < 3)   m_cnt_b++;
            end
        end
    endtask

    // One transaction: drive, clock, advance model, compare just after the edge.
    task automatic cyc(input logic r, input logic ld, input logic [7:0] p,
                       input logic v, input logic [1:0] s, input logic o, input logic c);
        res = r; load = ld; pat_in = p; sym_vld = v; sym_in = s; ovl = o; cnt_clr = c;
        @(posedge clk);
        model_step();
        #1;
        cyc_no++;
        if (y_a === 1'b1) pulse_cnt++;
        $display("cyc=%0d res=%b ld=%b pat=%h vld=%b sym=%0d ovl=%b clr=%b -> y=%b cnt=%0d/%0d armed=%b",
                 cyc_no, r, ld, p, v, s, o, c, y_a, match_cnt_a, match_cnt_b, armed_a);
        check("y",       32'(y_a),         32'(m_y));
        check("cnt_a",   32'(match_cnt_a), 32'(m_cnt_a));
        check("armed",   32'(armed_a),     32'(m_armed));
        check("y_b",     32'(y_b),         32'(m_y));
        check("cnt_b",   32'(match_cnt_b), 32'(m_cnt_b));
        check("armed_b", 32'(armed_b),     32'(m_armed));
    endtask

    task automatic send(input logic [1:0] s);
        cyc(1'b1, 1'b0, 8'h00, 1'b1, s, cur_ovl, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 8'h00, 1'b0, 2'b00, cur_ovl, 1'b0);
    endtask

    task automatic do_reset();
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 2'b00, cur_ovl, 1'b0);
    endtask

    task automatic send_seq39();
        send(2'b01); send(2'b10); send(2'b11); send(2'b00);
    endtask

    typedef struct {
        logic       res;
        logic       load;
        logic [7:0] pat;
        logic       vld;
        logic [1:0] sym;
        logic       exp_y;
        logic [7:0] exp_cnt;
        logic       exp_armed;
    } vec_t;

    vec_t vecs[9];

    initial begin
        res = 1'b0; load = 1'b0; pat_in = '0; sym_vld = 1'b0;
        sym_in = '0; ovl = 1'b1; cnt_clr = 1'b0;

        // Basic match with pattern 39 = symbols 01,10,11,00; idle ignores symbols
        vecs[0] = '{1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 8'd0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 8'h00, 1'b1, 2'b01, 1'b0, 8'd0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 8'h39, 1'b0, 2'b00, 1'b0, 8'd0, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 8'h00, 1'b1, 2'b01, 1'b0, 8'd0, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 8'h00, 1'b1, 2'b10, 1'b0, 8'd0, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 8'd0, 1'b1};
        vecs[6] = '{1'b1, 1'b0, 8'h00, 1'b1, 2'b11, 1'b0, 8'd0, 1'b1};
        vecs[7] = '{1'b1, 1'b0, 8'h00, 1'b1, 2'b00, 1'b1, 8'd1, 1'b1};
        vecs[8] = '{1'b1, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 8'd1, 1'b1};

        repeat (2) @(posedge clk);

        for (int i = 0; i < 9; i++) begin
            cyc(vecs[i].res, vecs[i].load, vecs[i].pat, vecs[i].vld, vecs[i].sym, 1'b1, 1'b0);
            check($sformatf("vec%0d_y", i),     32'(y_a),         32'(vecs[i].exp_y));
            check($sformatf("vec%0d_cnt", i),   32'(match_cnt_a), 32'(vecs[i].exp_cnt));
            check($sformatf("vec%0d_armed", i), 32'(armed_a),     32'(vecs[i].exp_armed));
        end

        // Overlapping mode: six 01 symbols against 55
        cur_ovl = 1'b1;
        do_reset();
        cyc(1'b1, 1'b1, 8'h55, 1'b0, 2'b00, 1'b1, 1'b0);
        pulse_cnt = 0;
        repeat (6) send(2'b01);
        idle(1);
        check("ovl1_pulses", 32'(pulse_cnt),   32'd3);
        check("ovl1_cnt",    32'(match_cnt_a), 32'd3);

        // Non-overlapping mode, reload with counter clear
        cur_ovl = 1'b0;
        cyc(1'b1, 1'b1, 8'h55, 1'b0, 2'b00, 1'b0, 1'b1);
        pulse_cnt = 0;
        repeat (6) send(2'b01);
        idle(1);
        check("ovl0_pulses", 32'(pulse_cnt),   32'd1);
        check("ovl0_cnt",    32'(match_cnt_a), 32'd1);

        // Gaps of three invalid cycles between symbols
        cur_ovl = 1'b1;
        do_reset();
        cyc(1'b1, 1'b1, 8'h39, 1'b0, 2'b00, 1'b1, 1'b0);
        pulse_cnt = 0;
        idle(3); send(2'b01);
        idle(3); send(2'b10);
        idle(3); send(2'b11);
        idle(3); send(2'b00);
        check("gap_latency", 32'(y_a), 32'd1);
        idle(2);
        check("gap_pulses", 32'(pulse_cnt), 32'd1);

        // Saturation on the narrow counter, then clear coincident with a match
        do_reset();
        cyc(1'b1, 1'b1, 8'h39, 1'b0, 2'b00, 1'b1, 1'b0);
        repeat (5) send_seq39();
        check("sat_cnt_b", 32'(match_cnt_b), 32'd3);
        check("sat_cnt_a", 32'(match_cnt_a), 32'd5);
        send(2'b01); send(2'b10); send(2'b11);
        cyc(1'b1, 1'b0, 8'h00, 1'b1, 2'b00, 1'b1, 1'b1);
        check("clr_match_y",   32'(y_a),         32'd1);
        check("clr_match_cnt", 32'(match_cnt_b), 32'd0);

        // Reset mid-stream (also overriding load, sym_vld and cnt_clr)
        do_reset();
        cyc(1'b1, 1'b1, 8'h39, 1'b0, 2'b00, 1'b1, 1'b0);
        send_seq39();
        send(2'b01); send(2'b10); send(2'b11);
        cyc(1'b0, 1'b1, 8'h39, 1'b1, 2'b00, 1'b1, 1'b1);
        check("rst_y",     32'(y_a),         32'd0);
        check("rst_armed", 32'(armed_a),     32'd0);
        check("rst_cnt",   32'(match_cnt_a), 32'd0);
        send(2'b00);
        check("rst_4th_y",     32'(y_a),     32'd0);
        check("rst_4th_armed", 32'(armed_a), 32'd0);
        pulse_cnt = 0;
        send_seq39();
        check("rst_noload_pulses", 32'(pulse_cnt), 32'd0);
        cyc(1'b1, 1'b1, 8'h39, 1'b0, 2'b00, 1'b1, 1'b0);
        send_seq39();
        check("rst_reload_pulses", 32'(pulse_cnt), 32'd1);

        // Load colliding with a valid symbol
        do_reset();
        cyc(1'b1, 1'b1, 8'h39, 1'b0, 2'b00, 1'b1, 1'b0);
        send(2'b01); send(2'b10); send(2'b11);
        cyc(1'b1, 1'b1, 8'h39, 1'b1, 2'b01, 1'b1, 1'b0);
        check("coll_armed", 32'(armed_a), 32'd1);
        check("coll_y",     32'(y_a),     32'd0);
        pulse_cnt = 0;
        send(2'b10); send(2'b11); send(2'b00);
        check("coll_discard_pulses", 32'(pulse_cnt), 32'd0);
        send(2'b01); send(2'b10); send(2'b11); send(2'b00);
        check("coll_full_y",      32'(y_a),       32'd1);
        check("coll_full_pulses", 32'(pulse_cnt), 32'd1);

        // Randomized traffic against the reference model
        do_reset();
        cyc(1'b1, 1'b1, 8'h39, 1'b0, 2'b00, 1'b1, 1'b0);
        for (int i = 0; i < 1500; i++) begin
            logic       r, ld, v, o, c;
            logic [7:0] p;
            logic [1:0] s;
            r  = ($urandom_range(0, 99) != 0);
            ld = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 1) == 0) begin
                p = '0;
                for (int k = 0; k < SEQ_LEN; k++) p[k*2 +: 2] = 2'($urandom_range(0, 1));
            end else begin
                p = 8'($urandom);
            end
            v = ($urandom_range(0, 3) != 0);
            s = ($urandom_range(0, 4) != 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(0, 3));
            o = 1'($urandom_range(0, 1));
            c = ($urandom_range(0, 39) == 0);
            cyc(r, ld, p, v, s, o, c);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
